// File: rtl/cdb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cdb_pkg                                                            |
// | Shared types and helpers for the common data bus arbiter.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cdb_pkg;

    localparam int ARCH_REGS     = 32;
    localparam int ARCH_W        = $clog2(ARCH_REGS);
    localparam int CDB_NUM_REGS  = 64;
    localparam int CDB_PS_WIDTH  = $clog2(CDB_NUM_REGS);
    localparam int CDB_ROB_DEPTH = 16;
    localparam int CDB_ROB_W     = $clog2(CDB_ROB_DEPTH);
    localparam int DATA_W        = 32;
    localparam int PTR_W         = 8;

    // Broadcast payload; field widths follow the package defaults above.
    typedef struct packed {
        logic [ARCH_W-1:0]       rd;
        logic [CDB_PS_WIDTH-1:0] pd;
        logic [CDB_ROB_W-1:0]    rob_idx;
        logic [DATA_W-1:0]       data;
    } cdb_entry_t;

    // Round-robin increment that wraps from 'last' back to zero.
    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                                 input logic [PTR_W-1:0] last);
        return (ptr == last) ? '0 : ptr + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter                                                         |
// | Combinational rotating-priority encoder: one-hot grant + index.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_grant_idx,
    output logic          o_grant_any
);

    int            w_idx;
    logic [PW-1:0] w_sel;

    // Scan from the farthest offset down so the requester nearest to i_ptr wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_idx       = 0;
        w_sel       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_sel = PW'(w_idx);
            if (i_req[w_sel]) begin
                o_grant        = '0;
                o_grant[w_sel] = 1'b1;
                o_grant_idx    = w_sel;
                o_grant_any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cdb_arbiter                                                        |
// | Round-robin sharing of the CDB between FU writeback ports.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_REGS  = CDB_NUM_REGS,
    parameter int PS_WIDTH  = $clog2(NUM_REGS),
    parameter int ROB_DEPTH = CDB_ROB_DEPTH,
    parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][ARCH_W-1:0]    req_rd,
    input  logic [NUM_REQ-1:0][PS_WIDTH-1:0]  req_pd,
    input  logic [NUM_REQ-1:0][ROB_W-1:0]     req_rob_idx,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
    input  logic                              jump_commit,
    output logic                              cdb_valid,
    output logic [ARCH_W-1:0]                 cdb_rd,
    output logic [PS_WIDTH-1:0]               cdb_pd,
    output logic                              cdb_regf_we,
    output logic [ROB_W-1:0]                  cdb_rob_idx,
    output logic [DATA_W-1:0]                 cdb_data
);

    localparam int c_PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_req_eff;
    logic [NUM_REQ-1:0] w_grant;
    logic [c_PTR_W-1:0] w_gidx;
    logic               w_any;
    cdb_entry_t         w_entries [NUM_REQ];

    logic               r_valid;
    cdb_entry_t         r_entry;
    logic [c_PTR_W-1:0] r_rr_ptr;

    // No handshake may complete during a flush or while reset is asserted.
    assign w_req_eff = (jump_commit || !rst_n) ? '0 : req_valid;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (c_PTR_W)
    ) u_rr_arbiter (
        .i_req       (w_req_eff),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_grant_any (w_any)
    );

    assign req_ready = w_grant;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_entry
            assign w_entries[i] = '{rd:      req_rd[i],
                                    pd:      req_pd[i],
                                    rob_idx: req_rob_idx[i],
                                    data:    req_data[i]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_entry  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_valid <= w_any;
            if (w_any) begin
                r_entry  <= w_entries[w_gidx];
                r_rr_ptr <= c_PTR_W'(rr_next(PTR_W'(w_gidx), PTR_W'(NUM_REQ - 1)));
            end
        end
    end

    // A flush also kills the broadcast already on the bus so a stale pd cannot
    // clear RAT busy bits after the RRF restore.
    assign cdb_valid   = r_valid & ~jump_commit;
    assign cdb_regf_we = cdb_valid & (r_entry.rd != '0);
    assign cdb_rd      = r_entry.rd;
    assign cdb_pd      = r_entry.pd;
    assign cdb_rob_idx = r_entry.rob_idx;
    assign cdb_data    = r_entry.data;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cdb_arbiter                                                     |
// | Directed self-checking bench for cdb_arbiter.                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cdb_arbiter;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][4:0]  req_rd;
    logic [3:0][5:0]  req_pd;
    logic [3:0][3:0]  req_rob_idx;
    logic [3:0][31:0] req_data;
    logic             jump_commit;
    logic             cdb_valid;
    logic [4:0]       cdb_rd;
    logic [5:0]       cdb_pd;
    logic             cdb_regf_we;
    logic [3:0]       cdb_rob_idx;
    logic [31:0]      cdb_data;

    int total = 0;
    int bad   = 0;

    cdb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_pd      (req_pd),
        .req_rob_idx (req_rob_idx),
        .req_data    (req_data),
        .jump_commit (jump_commit),
        .cdb_valid   (cdb_valid),
        .cdb_rd      (cdb_rd),
        .cdb_pd      (cdb_pd),
        .cdb_regf_we (cdb_regf_we),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_data    (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input int i, input logic [4:0] rd, input logic [5:0] pd,
                               input logic [3:0] rob, input logic [31:0] data);
        req_rd[i]      = rd;
        req_pd[i]      = pd;
        req_rob_idx[i] = rob;
        req_data[i]    = data;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        jump_commit = 1'b0;
        req_valid   = 4'b1111;
        for (int i = 0; i < 4; i++) set_payload(i, 5'(i + 1), 6'(i + 10), 4'(i), 32'hA0 + i);
        step();
        step();
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
        total++; if (cdb_regf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", cdb_regf_we); end
        total++; if ({cdb_rd, cdb_pd, cdb_rob_idx, cdb_data} !== 47'd0) begin bad++; $display("FAIL reset_payload got=%h exp=0", {cdb_rd, cdb_pd, cdb_rob_idx, cdb_data}); end
        total++; if (dut.r_rr_ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.r_rr_ptr); end
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
        req_valid = 4'b0000;
        step();
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b exp=0", cdb_valid); end
    endtask

    task automatic test_single();
        set_payload(2, 5'd5, 6'd40, 4'd3, 32'hDEAD_0002);
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready[%0d] got=%b exp=0100", c, req_ready); end
            step();
            total++; if (cdb_valid !== 1'b1 || cdb_regf_we !== 1'b1) begin bad++; $display("FAIL single_valid[%0d] got=%b%b exp=11", c, cdb_valid, cdb_regf_we); end
            total++; if (cdb_rd !== 5'd5 || cdb_pd !== 6'd40 || cdb_rob_idx !== 4'd3 || cdb_data !== 32'hDEAD_0002) begin bad++; $display("FAIL single_payload[%0d] got=%0d/%0d/%0d/%h exp=5/40/3/dead0002", c, cdb_rd, cdb_pd, cdb_rob_idx, cdb_data); end
        end
        req_valid = 4'b0000;
        step();
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", cdb_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        do_reset();
        for (int i = 0; i < 4; i++) set_payload(i, 5'(i + 1), 6'(i + 20), 4'(i + 8), 32'hC000 + i);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_ready = 4'b0001 << (k % 4);
            #1;
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_ready); end
            step();
            total++; if (cdb_valid !== 1'b1 || cdb_rob_idx !== 4'((k % 4) + 8) || cdb_data !== 32'hC000 + (k % 4)) begin bad++; $display("FAIL rr_cdb[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, cdb_valid, cdb_rob_idx, cdb_data, (k % 4) + 8, 32'hC000 + (k % 4)); end
        end
        req_valid = 4'b0000;
        step();
        total++; if (dut.r_rr_ptr !== 2'd1) begin bad++; $display("FAIL rr_ptr got=%0d exp=1", dut.r_rr_ptr); end
    endtask

    task automatic test_wrap();
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        #1;
        total++; if (dut.r_rr_ptr !== 2'd3) begin bad++; $display("FAIL wrap_setup_ptr got=%0d exp=3", dut.r_rr_ptr); end
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_ready got=%b exp=0010", req_ready); end
        step();
        req_valid = 4'b0000;
        #1;
        total++; if (dut.r_rr_ptr !== 2'd2) begin bad++; $display("FAIL wrap_ptr got=%0d exp=2", dut.r_rr_ptr); end
        step();
    endtask

    task automatic test_rd_zero();
        set_payload(0, 5'd0, 6'd7, 4'd5, 32'h0000_0777);
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rd0_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        #1;
        total++; if (cdb_valid !== 1'b1 || cdb_regf_we !== 1'b0 || cdb_pd !== 6'd7) begin bad++; $display("FAIL rd0_cdb got=%b/%b/%0d exp=1/0/7", cdb_valid, cdb_regf_we, cdb_pd); end
        step();
    endtask

    task automatic test_flush();
        set_payload(1, 5'd9, 6'd33, 4'd6, 32'h1111_2222);
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL flush_grant got=%b exp=0010", req_ready); end
        step();
        jump_commit = 1'b1;
        #1;
        total++; if (cdb_valid !== 1'b0 || cdb_regf_we !== 1'b0) begin bad++; $display("FAIL flush_t1_valid got=%b%b exp=00", cdb_valid, cdb_regf_we); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL flush_t1_ready got=%b exp=0000", req_ready); end
        step();
        jump_commit = 1'b0;
        req_valid   = 4'b0000;
        #1;
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_t2_valid got=%b exp=0", cdb_valid); end
        total++; if (dut.r_rr_ptr !== 2'd2) begin bad++; $display("FAIL flush_ptr got=%0d exp=2", dut.r_rr_ptr); end
    endtask

    task automatic test_reset_mid();
        set_payload(3, 5'd4, 6'd50, 4'd2, 32'h3333_3333);
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0000;
        total++; if (cdb_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", cdb_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (cdb_valid !== 1'b0 || cdb_regf_we !== 1'b0) begin bad++; $display("FAIL mid_async got=%b%b exp=00", cdb_valid, cdb_regf_we); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_rd_zero();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
